// File: rtl/seq_sdiv_pkg.sv
// Shared constants for the signed sequential divider: FSM encoding, default
// operand widths (matching the 8x8 multiplier path) and saturation values.
package seq_sdiv_pkg;

    localparam int unsigned MULT_OP_W      = 8;
    localparam int unsigned MULT_PROD_W    = 2 * MULT_OP_W;
    localparam int unsigned DIVIDEND_W_DEF = MULT_PROD_W;
    localparam int unsigned DIVISOR_W_DEF  = MULT_OP_W;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [MULT_PROD_W-1:0] SQ_MAX = 16'h7FFF;
    localparam logic [MULT_PROD_W-1:0] SQ_MIN = 16'h8000;

endpackage

// File: rtl/seq_sdiv_step.sv
// One restoring-division step: shift in the next dividend bit, subtract the
// divisor magnitude when it fits.
module seq_sdiv_step #(
    parameter int unsigned DIVISOR_W = 8
) (
    input  logic [DIVISOR_W-1:0] partial_i,
    input  logic                 bit_i,
    input  logic [DIVISOR_W-1:0] dmag_i,
    output logic [DIVISOR_W-1:0] partial_c_o,
    output logic                 qbit_c_o
);

    logic [DIVISOR_W:0] shifted_c;
    logic [DIVISOR_W:0] dmag_ext_c;

    // The remainder never reaches |divisor|, so the top bit of the difference is always zero.
    always_comb begin
        shifted_c   = {partial_i, bit_i};
        dmag_ext_c  = {1'b0, dmag_i};
        qbit_c_o    = (shifted_c >= dmag_ext_c);
        partial_c_o = qbit_c_o ? DIVISOR_W'(shifted_c - dmag_ext_c)
                               : DIVISOR_W'(shifted_c);
    end

endmodule

// File: rtl/seq_sdiv.sv
// Iterative signed restoring divider with start/busy/done handshake; quotient
// truncates toward zero, remainder follows the dividend sign.
module seq_sdiv
    import seq_sdiv_pkg::*;
#(
    parameter int unsigned DIVIDEND_W = DIVIDEND_W_DEF,
    parameter int unsigned DIVISOR_W  = DIVISOR_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  busy,
    output logic                  done,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  ovf,
    output logic                  dz
);

    localparam int unsigned CNT_W = $clog2(DIVIDEND_W);
    localparam logic [DIVIDEND_W-1:0] Q_MAX = {1'b0, {(DIVIDEND_W-1){1'b1}}};
    localparam logic [DIVIDEND_W-1:0] Q_MIN = {1'b1, {(DIVIDEND_W-1){1'b0}}};

    logic [1:0]            state_q, state_d;
    logic [DIVIDEND_W-1:0] dvd_q, dvd_d;
    logic [DIVISOR_W-1:0]  dvs_q, dvs_d;
    logic [DIVIDEND_W-1:0] dvd_mag_q, dvd_mag_d;
    logic [DIVISOR_W-1:0]  dvs_mag_q, dvs_mag_d;
    logic [DIVISOR_W-1:0]  partial_q, partial_d;
    logic [DIVIDEND_W-1:0] quot_q, quot_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [DIVIDEND_W-1:0] quotient_q, quotient_d;
    logic [DIVISOR_W-1:0]  remainder_q, remainder_d;
    logic                  ovf_q, ovf_d;
    logic                  dz_q, dz_d;

    logic [DIVISOR_W-1:0]  step_partial_c;
    logic                  step_qbit_c;
    logic                  q_neg_c;
    logic [DIVIDEND_W-1:0] q_signed_c;
    logic [DIVISOR_W-1:0]  r_signed_c;

    seq_sdiv_step #(
        .DIVISOR_W (DIVISOR_W)
    ) u_step (
        .partial_i   (partial_q),
        .bit_i       (dvd_mag_q[DIVIDEND_W-1]),
        .dmag_i      (dvs_mag_q),
        .partial_c_o (step_partial_c),
        .qbit_c_o    (step_qbit_c)
    );

    // Sign fix-up of the unsigned magnitudes produced by CALC.
    always_comb begin
        q_neg_c    = dvd_q[DIVIDEND_W-1] ^ dvs_q[DIVISOR_W-1];
        q_signed_c = q_neg_c ? (~quot_q + DIVIDEND_W'(1)) : quot_q;
        r_signed_c = dvd_q[DIVIDEND_W-1] ? (~partial_q + DIVISOR_W'(1)) : partial_q;
    end

    always_comb begin
        state_d     = state_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        dvd_mag_d   = dvd_mag_q;
        dvs_mag_d   = dvs_mag_q;
        partial_d   = partial_q;
        quot_d      = quot_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        ovf_d       = ovf_q;
        dz_d        = dz_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    dvd_d     = dividend;
                    dvs_d     = divisor;
                    dvd_mag_d = dividend[DIVIDEND_W-1] ? (~dividend + DIVIDEND_W'(1)) : dividend;
                    dvs_mag_d = divisor[DIVISOR_W-1] ? (~divisor + DIVISOR_W'(1)) : divisor;
                    partial_d = '0;
                    quot_d    = '0;
                    cnt_d     = CNT_W'(DIVIDEND_W - 1);
                    state_d   = ST_CALC;
                end
            end
            ST_CALC: begin
                dvd_mag_d = {dvd_mag_q[DIVIDEND_W-2:0], 1'b0};
                partial_d = step_partial_c;
                quot_d    = {quot_q[DIVIDEND_W-2:0], step_qbit_c};
                cnt_d     = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                if (dvs_mag_q == '0) begin
                    quotient_d  = dvd_q[DIVIDEND_W-1] ? Q_MIN : Q_MAX;
                    remainder_d = '0;
                    ovf_d       = 1'b0;
                    dz_d        = 1'b1;
                end else if ((dvd_q == Q_MIN) && (dvs_q == '1)) begin
                    quotient_d  = Q_MAX;
                    remainder_d = '0;
                    ovf_d       = 1'b1;
                    dz_d        = 1'b0;
                end else begin
                    quotient_d  = q_signed_c;
                    remainder_d = r_signed_c;
                    ovf_d       = 1'b0;
                    dz_d        = 1'b0;
                end
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            dvd_q       <= '0;
            dvs_q       <= '0;
            dvd_mag_q   <= '0;
            dvs_mag_q   <= '0;
            partial_q   <= '0;
            quot_q      <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            ovf_q       <= 1'b0;
            dz_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            dvd_mag_q   <= dvd_mag_d;
            dvs_mag_q   <= dvs_mag_d;
            partial_q   <= partial_d;
            quot_q      <= quot_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            ovf_q       <= ovf_d;
            dz_q        <= dz_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign ovf       = ovf_q;
    assign dz        = dz_q;

endmodule

// File: tb/tb_seq_sdiv.sv
// Directed and random checks of seq_sdiv against a truncating division model.
module tb_seq_sdiv;
    import seq_sdiv_pkg::*;

    typedef struct {
        logic [15:0] q;
        logic [7:0]  r;
        logic        ovf;
        logic        dz;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        ovf;
    logic        dz;

    int   checks    = 0;
    int   errors    = 0;
    int   cycle_cnt = 0;
    int   done_cnt  = 0;
    int   n_acc     = 0;
    int   t0        = 0;
    exp_t sb[$];

    seq_sdiv dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .ovf       (ovf),
        .dz        (dz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;
    always @(negedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

    function automatic exp_t model(input int a, input int b);
        exp_t e;
        int   q;
        int   r;
        e.ovf = 1'b0;
        e.dz  = 1'b0;
        if (b == 0) begin
            q    = (a >= 0) ? 32767 : -32768;
            r    = 0;
            e.dz = 1'b1;
        end else if (a == -32768 && b == -1) begin
            q     = 32767;
            r     = 0;
            e.ovf = 1'b1;
        end else begin
            q = a / b;
            r = a % b;
        end
        e.q = 16'(q);
        e.r = 8'(r);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic launch(input int a, input int b, input bit expect_res);
        @(negedge clk);
        start    = 1'b1;
        dividend = 16'(a);
        divisor  = 8'(b);
        t0       = cycle_cnt;
        if (expect_res) begin
            sb.push_back(model(a, b));
            n_acc++;
        end
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'(1));
    endtask

    task automatic wait_check(input string tag);
        int   lat;
        exp_t e;
        lat = -1;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) begin
                lat = cycle_cnt - t0;
                break;
            end
            @(negedge clk);
        end
        if (lat < 0 || sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s_timeout: observed no done/result expected done within 40 cycles", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, "_latency"}, 32'(lat), 32'(18));
            chk({tag, "_quotient"}, 32'(quotient), 32'(e.q));
            chk({tag, "_remainder"}, 32'(remainder), 32'(e.r));
            chk({tag, "_ovf"}, 32'(ovf), 32'(e.ovf));
            chk({tag, "_dz"}, 32'(dz), 32'(e.dz));
            chk({tag, "_busy_at_done"}, 32'(busy), 32'(1));
            @(negedge clk);
            chk({tag, "_done_pulse"}, 32'(done), 32'(0));
            chk({tag, "_idle_busy"}, 32'(busy), 32'(0));
            chk({tag, "_held"}, 32'(quotient), 32'(e.q));
        end
    endtask

    task automatic run(input int a, input int b, input string tag);
        launch(a, b, 1'b1);
        wait_check(tag);
    endtask

    initial begin
        int a;
        int b;
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_quotient", 32'(quotient), 32'(0));
        chk("rst_remainder", 32'(remainder), 32'(0));
        chk("rst_flags", 32'({ovf, dz}), 32'(0));
        rst = 1'b0;

        run(100, 7, "p100_p7");
        run(-100, 7, "n100_p7");
        run(100, -7, "p100_n7");
        run(-100, -7, "n100_n7");
        run(-32768, -1, "min_n1");
        run(-32768, 1, "min_p1");
        run(32767, -128, "max_n128");
        run(5, 0, "p5_dz");
        run(-5, 0, "n5_dz");
        run(0, 0, "zero_dz");

        // A second start while busy must not disturb the operation in flight.
        launch(100, 7, 1'b1);
        @(negedge clk);
        start    = 1'b1;
        dividend = 16'(9);
        divisor  = 8'(3);
        @(negedge clk);
        start = 1'b0;
        wait_check("ignored_start");
        run(9, 3, "p9_p3");

        // Reset in the middle of an operation aborts it without a done pulse.
        launch(1234, 5, 1'b0);
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'(0));
        chk("abort_done", 32'(done), 32'(0));
        chk("abort_quotient", 32'(quotient), 32'(0));
        chk("abort_remainder", 32'(remainder), 32'(0));
        chk("abort_flags", 32'({ovf, dz}), 32'(0));
        rst = 1'b0;
        run(1000, 10, "p1000_p10");

        for (int i = 0; i < 400; i++) begin
            a = int'($urandom_range(0, 65535)) - 32768;
            b = int'($urandom_range(0, 255)) - 128;
            if (b == 0 || (a == -32768 && b == -1)) b = 3;
            run(a, b, "random");
        end

        repeat (3) @(negedge clk);
        chk("done_count", 32'(done_cnt), 32'(n_acc));
        chk("sat_const", 32'(model(-32768, -1).q), 32'(SQ_MAX));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
